// File: rtl/replay_window_check_if.sv
// Message-in / result-out handshake bundle for replay_window_check.
// Ports (by modport):
//   master : drives in_valid, in_seq, in_mac_ok, res_ready; observes in_ready and res_*
//   slave  : the checker; takes messages and drives in_ready, res_valid, res_accept,
//            res_reason, res_seq
interface replay_window_check_if #(
  parameter int unsigned CNTR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CNTR_WIDTH-1:0] in_seq;
  logic                  in_mac_ok;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_accept;
  logic [1:0]            res_reason;
  logic [CNTR_WIDTH-1:0] res_seq;

  modport master (
    output in_valid, in_seq, in_mac_ok, res_ready,
    input  in_ready, res_valid, res_accept, res_reason, res_seq
  );

  modport slave (
    input  in_valid, in_seq, in_mac_ok, res_ready,
    output in_ready, res_valid, res_accept, res_reason, res_seq
  );
endinterface

// File: rtl/replay_window_check.sv
// Receive-side anti-replay check. Each authenticated message's sequence number is
// compared with the freshness counter (highest accepted seq) and a WINDOW-bit
// sliding bitmap of recently accepted seqs below it. Fresh messages ahead of the
// counter advance it through a one-cycle force strobe.
// Ports:
//   clk         in   rising-edge clock
//   resetn      in   synchronous active-low reset
//   bus         slave modport: in_valid/in_ready/in_seq/in_mac_ok request,
//               res_valid/res_ready/res_accept/res_reason/res_seq result
//   counter     in   current freshness counter value
//   force_bit   out  one-cycle load strobe to the freshness counter
//   force_value out  value to load, valid while force_bit=1
module replay_window_check #(
  parameter int unsigned CNTR_WIDTH = 32,
  parameter int unsigned WINDOW     = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  replay_window_check_if.slave  bus,
  input  logic [CNTR_WIDTH-1:0] counter,
  output logic                  force_bit,
  output logic [CNTR_WIDTH-1:0] force_value
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_RESP} state_t;
  typedef enum logic [1:0] {
    RSN_OK      = 2'b00,
    RSN_BAD_MAC = 2'b01,
    RSN_REPLAY  = 2'b10,
    RSN_STALE   = 2'b11
  } reason_t;

  // Largest forward distance still treated as "ahead" (half the number space).
  localparam logic [CNTR_WIDTH-1:0] HALF_MAX = {1'b0, {(CNTR_WIDTH-1){1'b1}}};
  localparam logic [CNTR_WIDTH-1:0] WIN_C    = CNTR_WIDTH'(WINDOW);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNTR_WIDTH-1:0] r_seq;
  logic                  r_mac_ok;
  logic [WINDOW-1:0]     r_bitmap;
  logic [WINDOW-1:0]     r_bitmap_upd;
  reason_t               r_reason;

  logic                  r_in_ready;
  logic                  r_res_valid;
  logic                  r_res_accept;
  reason_t               r_res_reason;
  logic [CNTR_WIDTH-1:0] r_res_seq;
  logic                  r_force_bit;
  logic [CNTR_WIDTH-1:0] r_force_value;

  logic [CNTR_WIDTH-1:0] w_d;
  logic [CNTR_WIDTH-1:0] w_b;
  logic                  w_is_ahead;
  logic [WINDOW-1:0]     w_bmask;
  reason_t               w_reason;
  logic                  w_ahead;
  logic [WINDOW-1:0]     w_bitmap_nxt;
  logic                  w_take;
  logic                  w_in_ready_nxt;
  logic                  w_res_valid_nxt;
  logic                  w_force_bit_nxt;

  // Modular distances between the captured seq and the counter.
  assign w_d        = r_seq - counter;
  assign w_b        = counter - r_seq;
  assign w_is_ahead = (w_d != '0) && (w_d <= HALF_MAX);
  assign w_bmask    = (w_b < WIN_C) ? (WINDOW'(1) << w_b) : '0;
  assign w_take     = (r_state == S_IDLE) && bus.in_valid && r_in_ready;

  // Verdict and post-acceptance bitmap for the captured message.
  always_comb begin
    w_reason     = RSN_OK;
    w_ahead      = 1'b0;
    w_bitmap_nxt = r_bitmap;
    if (!r_mac_ok) begin
      w_reason = RSN_BAD_MAC;
    end else if (w_is_ahead) begin
      w_ahead      = 1'b1;
      w_bitmap_nxt = (w_d >= WIN_C) ? WINDOW'(1) : ((r_bitmap << w_d) | WINDOW'(1));
    end else if (w_b >= WIN_C) begin
      w_reason = RSN_STALE;
    end else if (|(r_bitmap & w_bmask)) begin
      w_reason = RSN_REPLAY;
    end else begin
      w_bitmap_nxt = r_bitmap | w_bmask;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of the registered handshake/strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_take) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_RESP;
      S_RESP:   if (bus.res_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_res_valid_nxt = (w_state_nxt == S_RESP);
    w_force_bit_nxt = (r_state == S_CHECK) && w_ahead;
  end

  // Capture, verdict, bitmap and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_seq         <= '0;
      r_mac_ok      <= 1'b0;
      r_bitmap      <= '0;
      r_bitmap_upd  <= '0;
      r_reason      <= RSN_OK;
      r_in_ready    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_accept  <= 1'b0;
      r_res_reason  <= RSN_OK;
      r_res_seq     <= '0;
      r_force_bit   <= 1'b0;
      r_force_value <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_force_bit <= w_force_bit_nxt;
      if (w_take) begin
        r_seq    <= bus.in_seq;
        r_mac_ok <= bus.in_mac_ok;
      end
      if (r_state == S_CHECK) begin
        r_reason     <= w_reason;
        r_bitmap_upd <= w_bitmap_nxt;
        if (w_ahead) r_force_value <= r_seq;
      end
      // Bitmap commits together with the counter load at the end of UPDATE.
      if (r_state == S_UPDATE) begin
        r_bitmap     <= r_bitmap_upd;
        r_res_accept <= (r_reason == RSN_OK);
        r_res_reason <= r_reason;
        r_res_seq    <= r_seq;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_accept = r_res_accept;
  assign bus.res_reason = r_res_reason;
  assign bus.res_seq    = r_res_seq;
  assign force_bit      = r_force_bit;
  assign force_value    = r_force_value;

endmodule
